// File: rtl/lane_bundle_pkg.sv
// Shared types and constants for the lane bundle receiver.
// Hamming(21,16): parity bit i sits at code position 2^i; data bits 0..15 occupy
// the remaining positions 3,5,6,7,9..15,17..21 in ascending order.
package lane_bundle_pkg;

  localparam int LANES  = 5;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;
  localparam int PAR_W  = 5;
  localparam int CODE_W = DATA_W + PAR_W;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_e;

  // Code position of each data bit (index 0 is the rightmost entry).
  localparam logic [DATA_W-1:0][PAR_W-1:0] DATA_POS = {
    5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd13,
    5'd12, 5'd11, 5'd10, 5'd9,  5'd7,  5'd6,  5'd5,  5'd3
  };

  // PAR_MASK[i]: data bits whose code position has bit i set.
  localparam logic [PAR_W-1:0][DATA_W-1:0] PAR_MASK = {
    16'hF800, 16'h07F0, 16'hC78E, 16'h366D, 16'hAD5B
  };

  // One queued word.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  lane;
    err_e              err;
  } fifo_entry_t;

  // Check bits a transmitter would attach to this payload.
  function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] par;
    for (int i = 0; i < PAR_W; i++) begin
      par[i] = ^(data & PAR_MASK[i]);
    end
    return par;
  endfunction

endpackage

// File: rtl/lane_hamming_dec.sv
// Combinational single-error-correcting Hamming(21,16) decoder.
module lane_hamming_dec
  import lane_bundle_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [PAR_W-1:0]  par_i,
  output logic [DATA_W-1:0] data_o,
  output err_e              err_o
);

  logic [PAR_W-1:0] syn;

  // Syndrome points at the failing code position; flip it when it is a data bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    syn    = par_i ^ calc_parity(data_i);
    data_o = data_i;
    err_o  = ERR_NONE;
    if (syn == '0) begin
      err_o = ERR_NONE;
    end else if (syn > PAR_W'(CODE_W)) begin
      err_o = ERR_UNCORR;
    end else begin
      // Power-of-two syndromes hit a check bit: no DATA_POS matches, payload passes untouched.
      err_o = ERR_CORR;
      for (int j = 0; j < DATA_W; j++) begin
        if (syn == DATA_POS[j]) data_o[j] = ~data_i[j];
      end
    end
  end

endmodule

// File: rtl/lane_bundle_rx.sv
// Receive end of the 5-lane {data,valid,parity} bundle: lane capture, Hamming
// correction, output FIFO with ready/valid, saturating status counters.
// Build option: LANE_RX_DROP_UNCORR_EN keeps uncorrectable words out of the FIFO.
module lane_bundle_rx
  import lane_bundle_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_W      = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_in_0_data,
  input  logic              io_in_0_valid,
  input  logic [PAR_W-1:0]  io_in_0_parity,
  input  logic [DATA_W-1:0] io_in_1_data,
  input  logic              io_in_1_valid,
  input  logic [PAR_W-1:0]  io_in_1_parity,
  input  logic [DATA_W-1:0] io_in_2_data,
  input  logic              io_in_2_valid,
  input  logic [PAR_W-1:0]  io_in_2_parity,
  input  logic [DATA_W-1:0] io_in_3_data,
  input  logic              io_in_3_valid,
  input  logic [PAR_W-1:0]  io_in_3_parity,
  input  logic [DATA_W-1:0] io_in_4_data,
  input  logic              io_in_4_valid,
  input  logic [PAR_W-1:0]  io_in_4_parity,
  input  logic [SEL_W-1:0]  io_sel,
  input  logic              io_clr_cnt,
  input  logic              io_out_ready,
  output logic              io_out_valid,
  output logic [DATA_W-1:0] io_out_data,
  output logic [SEL_W-1:0]  io_out_lane,
  output logic [1:0]        io_out_err,
  output logic [LVL_W-1:0]  io_level,
  output logic [CNT_W-1:0]  io_corr_cnt,
  output logic [CNT_W-1:0]  io_uncorr_cnt,
  output logic [CNT_W-1:0]  io_drop_cnt
);

  // Lane mux
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [PAR_W-1:0]  sel_par;

  // Stage 1 capture registers
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [PAR_W-1:0]  s1_par_q, s1_par_d;
  logic [SEL_W-1:0]  s1_lane_q, s1_lane_d;

  // Stage 2 decode
  logic [DATA_W-1:0] dec_data;
  err_e              dec_err;

  // FIFO
  fifo_entry_t       fifo_mem_q [FIFO_DEPTH];
  fifo_entry_t       head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full, pop, push_req, push, drop;

  // Counters
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Route the selected lane; out-of-range selects present nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_par   = '0;
    case (io_sel)
      3'd0: begin sel_valid = io_in_0_valid; sel_data = io_in_0_data; sel_par = io_in_0_parity; end
      3'd1: begin sel_valid = io_in_1_valid; sel_data = io_in_1_data; sel_par = io_in_1_parity; end
      3'd2: begin sel_valid = io_in_2_valid; sel_data = io_in_2_data; sel_par = io_in_2_parity; end
      3'd3: begin sel_valid = io_in_3_valid; sel_data = io_in_3_data; sel_par = io_in_3_parity; end
      3'd4: begin sel_valid = io_in_4_valid; sel_data = io_in_4_data; sel_par = io_in_4_parity; end
      default: ;
    endcase
  end

  lane_hamming_dec u_dec (
    .data_i (s1_data_q),
    .par_i  (s1_par_q),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  assign full         = (level_q == LVL_W'(FIFO_DEPTH));
  assign io_out_valid = (level_q != '0);
  assign pop          = io_out_valid && io_out_ready;
  assign head         = fifo_mem_q[rd_ptr_q];

`ifdef LANE_RX_DROP_UNCORR_EN
  assign push_req = s1_valid_q && (dec_err != ERR_UNCORR);
`else
  assign push_req = s1_valid_q;
`endif

  // A pop in the same cycle frees the slot the push needs.
  assign push = push_req && (!full || pop);
  assign drop = push_req && !push;

  // Next-state for capture stage, FIFO pointers and status counters.
  always_comb begin
    s1_valid_d = sel_valid;
    s1_data_d  = sel_valid ? sel_data : s1_data_q;
    s1_par_d   = sel_valid ? sel_par : s1_par_q;
    s1_lane_d  = sel_valid ? io_sel : s1_lane_q;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + LVL_W'(1);
    if (pop && !push) level_d = level_q - LVL_W'(1);

    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (io_clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      drop_cnt_d   = '0;
    end else begin
      if (s1_valid_q && dec_err == ERR_CORR && corr_cnt_q != '1)
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (s1_valid_q && dec_err == ERR_UNCORR && uncorr_cnt_q != '1)
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      if (drop && drop_cnt_q != '1)
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Control and status state, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_par_q     <= '0;
      s1_lane_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_par_q     <= s1_par_d;
      s1_lane_q    <= s1_lane_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; stale entries are unobservable because outputs are gated by level.
    if (push) fifo_mem_q[wr_ptr_q] <= '{data: dec_data, lane: s1_lane_q, err: dec_err};
  end

  assign io_out_data   = io_out_valid ? head.data : '0;
  assign io_out_lane   = io_out_valid ? head.lane : '0;
  assign io_out_err    = io_out_valid ? head.err : ERR_NONE;
  assign io_level      = level_q;
  assign io_corr_cnt   = corr_cnt_q;
  assign io_uncorr_cnt = uncorr_cnt_q;
  assign io_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_lane_bundle_rx.sv
// Self-checking bench for lane_bundle_rx: directed literal checks plus a
// randomized run compared every cycle against a queue-based behavioural model.
// Honors LANE_RX_DROP_UNCORR_EN the same way the design does.
module tb_lane_bundle_rx;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LANE_RX_DROP_UNCORR_EN
  localparam bit DROP_UNCORR = 1'b1;
`else
  localparam bit DROP_UNCORR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data  [5];
  logic        in_valid [5];
  logic [4:0]  in_par   [5];
  logic [2:0]  io_sel = 3'd7;
  logic        io_clr_cnt = 1'b0;
  logic        io_out_ready = 1'b0;
  logic        io_out_valid;
  logic [15:0] io_out_data;
  logic [2:0]  io_out_lane;
  logic [1:0]  io_out_err;
  logic [2:0]  io_level;
  logic [7:0]  io_corr_cnt, io_uncorr_cnt, io_drop_cnt;

  always #5 clock = ~clock;

  lane_bundle_rx dut (
    .clock(clock), .reset(reset),
    .io_in_0_data(in_data[0]), .io_in_0_valid(in_valid[0]), .io_in_0_parity(in_par[0]),
    .io_in_1_data(in_data[1]), .io_in_1_valid(in_valid[1]), .io_in_1_parity(in_par[1]),
    .io_in_2_data(in_data[2]), .io_in_2_valid(in_valid[2]), .io_in_2_parity(in_par[2]),
    .io_in_3_data(in_data[3]), .io_in_3_valid(in_valid[3]), .io_in_3_parity(in_par[3]),
    .io_in_4_data(in_data[4]), .io_in_4_valid(in_valid[4]), .io_in_4_parity(in_par[4]),
    .io_sel(io_sel), .io_clr_cnt(io_clr_cnt), .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid), .io_out_data(io_out_data), .io_out_lane(io_out_lane),
    .io_out_err(io_out_err), .io_level(io_level),
    .io_corr_cnt(io_corr_cnt), .io_uncorr_cnt(io_uncorr_cnt), .io_drop_cnt(io_drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Check bits = XOR of the code positions of all set data bits.
  function automatic logic [4:0] enc(input logic [15:0] d);
    int k;
    int s;
    k = 0;
    s = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if (!is_pow2(pos)) begin
        if (d[k]) s = s ^ pos;
        k++;
      end
    end
    return 5'(s);
  endfunction

  // Build the 21-bit codeword, syndrome = XOR of positions of set bits.
  task automatic model_decode(input logic [15:0] d, input logic [4:0] p,
                              output logic [15:0] dout, output logic [1:0] err);
    logic [21:0] cw;
    int k;
    int pi;
    int s;
    cw = '0;
    k = 0;
    pi = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if (is_pow2(pos)) begin cw[pos] = p[pi]; pi++; end
      else begin cw[pos] = d[k]; k++; end
    end
    s = 0;
    for (int pos = 1; pos <= 21; pos++) if (cw[pos]) s = s ^ pos;
    if (s == 0) err = 2'b00;
    else if (s <= 21) begin err = 2'b01; cw[s] = ~cw[s]; end
    else err = 2'b10;
    k = 0;
    dout = '0;
    for (int pos = 1; pos <= 21; pos++) begin
      if (!is_pow2(pos)) begin dout[k] = cw[pos]; k++; end
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [2:0]  l;
    logic [1:0]  e;
  } ent_t;

  ent_t        mq[$];
  logic        m_s1_v = 1'b0;
  logic [15:0] m_s1_d = '0;
  logic [4:0]  m_s1_p = '0;
  logic [2:0]  m_s1_l = '0;
  int          m_corr = 0, m_uncorr = 0, m_drop = 0;
  bit          started = 1'b0;

  always @(posedge clock or posedge reset) begin : model_upd
    bit          pop_m;
    bit          push_m;
    ent_t        e;
    logic [15:0] dd;
    logic [1:0]  ee;
    int          sidx;
    if (reset) begin
      mq.delete();
      m_s1_v = 1'b0;
      m_corr = 0;
      m_uncorr = 0;
      m_drop = 0;
    end else begin
      pop_m  = (mq.size() > 0) && io_out_ready;
      push_m = 1'b0;
      if (m_s1_v) begin
        model_decode(m_s1_d, m_s1_p, dd, ee);
        e.d = dd;
        e.l = m_s1_l;
        e.e = ee;
        if (ee == 2'b01 && m_corr < CNT_MAX) m_corr++;
        if (ee == 2'b10 && m_uncorr < CNT_MAX) m_uncorr++;
        if (ee != 2'b10 || !DROP_UNCORR) begin
          if (mq.size() < DEPTH || pop_m) push_m = 1'b1;
          else if (m_drop < CNT_MAX) m_drop++;
        end
      end
      if (io_clr_cnt) begin m_corr = 0; m_uncorr = 0; m_drop = 0; end
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(e);
      sidx = int'(io_sel);
      m_s1_v = 1'b0;
      if (sidx < 5) begin
        if (in_valid[sidx]) begin
          m_s1_v = 1'b1;
          m_s1_d = in_data[sidx];
          m_s1_p = in_par[sidx];
          m_s1_l = io_sel;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      if (mq.size() > 0) begin
        check("model_valid", 32'(io_out_valid), 32'd1);
        check("model_data",  32'(io_out_data), 32'(mq[0].d));
        check("model_lane",  32'(io_out_lane), 32'(mq[0].l));
        check("model_err",   32'(io_out_err),  32'(mq[0].e));
      end else begin
        check("model_valid", 32'(io_out_valid), 32'd0);
        check("model_data",  32'(io_out_data), 32'd0);
        check("model_lane",  32'(io_out_lane), 32'd0);
        check("model_err",   32'(io_out_err),  32'd0);
      end
      check("model_level",  32'(io_level),      32'(mq.size()));
      check("model_corr",   32'(io_corr_cnt),   32'(m_corr));
      check("model_uncorr", 32'(io_uncorr_cnt), 32'(m_uncorr));
      check("model_drop",   32'(io_drop_cnt),   32'(m_drop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_lanes();
    for (int i = 0; i < 5; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      in_par[i]   = '0;
    end
  endtask

  // Present one word on a lane for a single capture edge, then let it reach the FIFO.
  task automatic send_one(input int lane, input logic [15:0] d, input logic [4:0] p);
    io_sel = 3'(lane);
    in_valid[lane] = 1'b1;
    in_data[lane]  = d;
    in_par[lane]   = p;
    tick();
    in_valid[lane] = 1'b0;
    check("latency_not_early", 32'(io_out_valid && io_level == 0), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pop_head();
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(io_out_valid),  32'd0);
    check({tag, "_data"},   32'(io_out_data),   32'd0);
    check({tag, "_lane"},   32'(io_out_lane),   32'd0);
    check({tag, "_err"},    32'(io_out_err),    32'd0);
    check({tag, "_level"},  32'(io_level),      32'd0);
    check({tag, "_corr"},   32'(io_corr_cnt),   32'd0);
    check({tag, "_uncorr"}, 32'(io_uncorr_cnt), 32'd0);
    check({tag, "_drop"},   32'(io_drop_cnt),   32'd0);
  endtask

  initial begin
    idle_lanes();
    #1 reset = 1'b1;
    started = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Model sanity pins: known encodings.
    check("enc_bit0", 32'(enc(16'h0001)), 32'h03);
    check("enc_bit15", 32'(enc(16'h8000)), 32'h15);

    // Clean word on lane 2.
    send_one(2, 16'h0000, 5'b00000);
    check("clean_valid", 32'(io_out_valid), 32'd1);
    check("clean_data", 32'(io_out_data), 32'h0000);
    check("clean_err", 32'(io_out_err), 32'd0);
    check("clean_lane", 32'(io_out_lane), 32'd2);
    pop_head();
    check("clean_popped", 32'(io_level), 32'd0);

    // Single data-bit error (syndrome 3).
    send_one(2, 16'h0001, 5'b00000);
    check("dflip_data", 32'(io_out_data), 32'h0000);
    check("dflip_err", 32'(io_out_err), 32'd1);
    check("dflip_corr", 32'(io_corr_cnt), 32'd1);
    pop_head();

    // Check-bit error.
    send_one(2, 16'h0000, 5'b00001);
    check("pflip_data", 32'(io_out_data), 32'h0000);
    check("pflip_err", 32'(io_out_err), 32'd1);
    check("pflip_corr", 32'(io_corr_cnt), 32'd2);
    pop_head();

    // Uncorrectable syndrome 31.
    send_one(2, 16'h0000, 5'b11111);
    check("uncorr_cnt", 32'(io_uncorr_cnt), 32'd1);
    if (DROP_UNCORR) begin
      check("uncorr_dropped_valid", 32'(io_out_valid), 32'd0);
      check("uncorr_dropped_level", 32'(io_level), 32'd0);
    end else begin
      check("uncorr_valid", 32'(io_out_valid), 32'd1);
      check("uncorr_err", 32'(io_out_err), 32'd2);
      check("uncorr_data", 32'(io_out_data), 32'h0000);
    end
    pop_head();

    // Full FIFO: six back-to-back words with the consumer stalled.
    io_sel = 3'd1;
    for (int i = 0; i < 6; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 16'h1111 * 16'(i + 1);
      in_par[1]   = enc(in_data[1]);
      tick();
    end
    in_valid[1] = 1'b0;
    tick();
    check("full_level", 32'(io_level), 32'd4);
    check("full_drop", 32'(io_drop_cnt), 32'd2);
    io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_order_data", 32'(io_out_data), 32'(16'h1111 * 16'(i + 1)));
      check("full_order_lane", 32'(io_out_lane), 32'd1);
      tick();
    end
    check("full_drained", 32'(io_out_valid), 32'd0);
    io_out_ready = 1'b0;

    // Out-of-range select captures nothing.
    io_sel = 3'd5;
    for (int i = 0; i < 5; i++) begin
      in_valid[i] = 1'b1;
      in_data[i]  = 16'(i);
      in_par[i]   = enc(16'(i));
    end
    for (int c = 0; c < 10; c++) tick();
    tick();
    check("sel5_valid", 32'(io_out_valid), 32'd0);
    check("sel5_level", 32'(io_level), 32'd0);
    idle_lanes();

    // Mid-stream reset with three queued words.
    io_sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      in_valid[3] = 1'b1;
      in_data[3]  = 16'hA000 + 16'(i);
      in_par[3]   = enc(in_data[3]) ^ 5'b00100;
      tick();
    end
    in_valid[3] = 1'b0;
    tick();
    check("midrst_level_before", 32'(io_level), 32'd3);
    reset = 1'b1;
    #1;
    check_all_zero("midrst_async");
    tick();
    check_all_zero("midrst_next");
    reset = 1'b0;

    // Counter saturation: 260 corrected words.
    io_sel = 3'd4;
    io_out_ready = 1'b1;
    in_valid[4] = 1'b1;
    in_data[4]  = 16'h0001;
    in_par[4]   = 5'b00000;
    for (int i = 0; i < 260; i++) tick();
    in_valid[4] = 1'b0;
    tick();
    tick();
    check("sat_corr", 32'(io_corr_cnt), 32'd255);
    io_clr_cnt = 1'b1;
    tick();
    io_clr_cnt = 1'b0;
    check("clr_corr", 32'(io_corr_cnt), 32'd0);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      io_sel = 3'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++) begin
        int unsigned mode;
        int unsigned r;
        logic [15:0] d;
        logic [4:0]  p;
        d = 16'($urandom);
        p = enc(d);
        mode = $urandom_range(0, 3);
        if (mode == 2) begin
          r = $urandom_range(0, 20);
          if (r < 16) d[r] = ~d[r];
          else p[r-16] = ~p[r-16];
        end else if (mode == 3) begin
          p = 5'($urandom);
        end
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = d;
        in_par[i]   = p;
      end
      io_out_ready = ($urandom_range(0, 2) != 0);
      io_clr_cnt   = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle_lanes();
    io_clr_cnt = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
